controlador_sinc_vga: RTL and testbench

CONTROLADOR_SINC_VGA -- requirements
Module: controlador_sinc_vga

---
 rtl/controlador_sinc_vga.sv | 132 +++++++++++++
 tb/tb_controlador_sinc_vga.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/controlador_sinc_vga.sv
// controlador_sinc_vga: VGA sync generator.
//   A pixel divider produces one tick every DIV_PIXEL clk cycles. Each tick advances the
//   horizontal pixel counter. The vertical line counter advances whenever the horizontal
//   counter wraps. Phase registers (VISIBLE/FRONT/SYNC/BACK) are decoded from the
//   next-state counter values, so the sync and blanking outputs are registered and line
//   up with the counter values on the same clk.
// Ports:
//   clk        - only clock, rising edge
//   reset      - synchronous, active-high
//   habilitar  - run enable; low freezes all state
//   tick_pixel - one-clk pulse per pixel period
//   cuentaH    - horizontal pixel count, 0..H_TOTAL-1
//   cuentaV    - vertical line count, 0..V_TOTAL-1
//   Hsinc      - horizontal sync, active low
//   Vsinc      - vertical sync, active low
//   video_on   - high inside the visible area
//   fin_linea  - one-clk pulse after the horizontal wrap
//   fin_cuadro - one-clk pulse after the frame wrap
module controlador_sinc_vga #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter int unsigned DIV_PIXEL = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       habilitar,
   output logic       tick_pixel,
   output logic [9:0] cuentaH,
   output logic [9:0] cuentaV,
   output logic       Hsinc,
   output logic       Vsinc,
   output logic       video_on,
   output logic       fin_linea,
   output logic       fin_cuadro
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   typedef enum logic [1:0] {FaseVisible, FaseFront, FaseSync, FaseBack} fase_e;

   logic [3:0] div_q, div_d;
   logic [9:0] cuenta_h_q, cuenta_h_d;
   logic [9:0] cuenta_v_q, cuenta_v_d;
   fase_e      fase_h_q, fase_h_d;
   fase_e      fase_v_q, fase_v_d;
   logic       hsinc_q, vsinc_q, video_q;
   logic       fin_linea_q, fin_cuadro_q;
   logic       tick, wrap_h, wrap_v;

   // Range decode of a counter value into its phase.
   function automatic fase_e decodifica(input logic [9:0] c, input int unsigned vis,
                                        input int unsigned fr, input int unsigned sy);
      int unsigned x;
      x = {22'd0, c};
      if (x < vis) begin
         return FaseVisible;
      end else if (x < vis + fr) begin
         return FaseFront;
      end else if (x < vis + fr + sy) begin
         return FaseSync;
      end else begin
         return FaseBack;
      end
   endfunction

   // Next-state logic for the divider, counters and both phase FSMs.
   always_comb begin
      tick       = habilitar && (div_q == 4'(DIV_PIXEL - 1));
      wrap_h     = tick && (cuenta_h_q == 10'(H_TOTAL - 1));
      wrap_v     = wrap_h && (cuenta_v_q == 10'(V_TOTAL - 1));
      div_d      = div_q;
      cuenta_h_d = cuenta_h_q;
      cuenta_v_d = cuenta_v_q;
      if (habilitar) begin
         div_d = tick ? 4'd0 : div_q + 4'd1;
      end
      if (tick) begin
         cuenta_h_d = wrap_h ? 10'd0 : cuenta_h_q + 10'd1;
      end
      if (wrap_h) begin
         cuenta_v_d = wrap_v ? 10'd0 : cuenta_v_q + 10'd1;
      end
      // Phases follow the counter values that will be loaded on this edge, so the
      // registered outputs describe the same position as cuentaH/cuentaV.
      fase_h_d = decodifica(cuenta_h_d, H_VISIBLE, H_FRONT, H_SYNC);
      fase_v_d = decodifica(cuenta_v_d, V_VISIBLE, V_FRONT, V_SYNC);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         div_q        <= 4'd0;
         cuenta_h_q   <= 10'd0;
         cuenta_v_q   <= 10'd0;
         fase_h_q     <= FaseVisible;
         fase_v_q     <= FaseVisible;
         hsinc_q      <= 1'b1;
         vsinc_q      <= 1'b1;
         video_q      <= 1'b1;
         fin_linea_q  <= 1'b0;
         fin_cuadro_q <= 1'b0;
      end else begin
         div_q        <= div_d;
         cuenta_h_q   <= cuenta_h_d;
         cuenta_v_q   <= cuenta_v_d;
         fase_h_q     <= fase_h_d;
         fase_v_q     <= fase_v_d;
         hsinc_q      <= (fase_h_d != FaseSync);
         vsinc_q      <= (fase_v_d != FaseSync);
         video_q      <= (fase_h_d == FaseVisible) && (fase_v_d == FaseVisible);
         fin_linea_q  <= wrap_h;
         fin_cuadro_q <= wrap_v;
      end
   end

   assign tick_pixel = tick;
   assign cuentaH    = cuenta_h_q;
   assign cuentaV    = cuenta_v_q;
   assign Hsinc      = hsinc_q;
   assign Vsinc      = vsinc_q;
   assign video_on   = video_q;
   // Pulses are suppressed while paused.
   assign fin_linea  = fin_linea_q && habilitar;
   assign fin_cuadro = fin_cuadro_q && habilitar;

endmodule

// File: tb/tb_controlador_sinc_vga.sv
// Bench for controlador_sinc_vga. Default horizontal timing; a short vertical frame
// (12 visible, 1 front, 2 sync, 1 back = 16 lines) keeps the run small.
module tb_controlador_sinc_vga;

   localparam int unsigned VV = 12;
   localparam int unsigned VF = 1;
   localparam int unsigned VS = 2;
   localparam int unsigned VB = 1;
   localparam int unsigned LARGO_CUADRO = 800 * (VV + VF + VS + VB) * 2;
   localparam int LIMITE = 30000;

   logic       clk = 1'b0;
   logic       reset;
   logic       habilitar;
   logic       tick_pixel;
   logic [9:0] cuentaH, cuentaV;
   logic       Hsinc, Vsinc, video_on, fin_linea, fin_cuadro;

   controlador_sinc_vga #(
      .H_VISIBLE(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .DIV_PIXEL(2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .habilitar (habilitar),
      .tick_pixel(tick_pixel),
      .cuentaH   (cuentaH),
      .cuentaV   (cuentaV),
      .Hsinc     (Hsinc),
      .Vsinc     (Vsinc),
      .video_on  (video_on),
      .fin_linea (fin_linea),
      .fin_cuadro(fin_cuadro)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      nombre;
      logic [9:0] h;
      logic [9:0] v;
      logic       tk, hs, vs, vid, fl, fc;
   } esperado_t;

   esperado_t cola[$];
   esperado_t e;
   int checks   = 0;
   int errores  = 0;
   int ciclos   = 0;
   int vs_fuera = 0;
   int c0       = 0;

   always @(posedge clk) ciclos <= ciclos + 1;

   // Monitor: compares DUT outputs against the oldest queued expectation.
   always @(negedge clk) begin
      if (cola.size() != 0) begin
         e = cola.pop_front();
         checks++;
         if ({cuentaH, cuentaV, tick_pixel, Hsinc, Vsinc, video_on, fin_linea, fin_cuadro} !==
             {e.h, e.v, e.tk, e.hs, e.vs, e.vid, e.fl, e.fc}) begin
            errores++;
            $display("FAIL %s: got h=%0d v=%0d tick=%b hs=%b vs=%b vid=%b fl=%b fc=%b, want h=%0d v=%0d tick=%b hs=%b vs=%b vid=%b fl=%b fc=%b",
                     e.nombre, cuentaH, cuentaV, tick_pixel, Hsinc, Vsinc, video_on,
                     fin_linea, fin_cuadro, e.h, e.v, e.tk, e.hs, e.vs, e.vid, e.fl, e.fc);
         end
      end
      if (Vsinc === 1'b0 && !(cuentaV == 10'd13 || cuentaV == 10'd14)) vs_fuera++;
   end

   task automatic ciclo(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic empuja(input string n, input int h, input int v, input logic tk,
                         input logic hs, input logic vs, input logic vid,
                         input logic fl, input logic fc);
      esperado_t x;
      x.nombre = n;
      x.h = 10'(h);
      x.v = 10'(v);
      x.tk = tk;
      x.hs = hs;
      x.vs = vs;
      x.vid = vid;
      x.fl = fl;
      x.fc = fc;
      cola.push_back(x);
   endtask

   // Advance until the DUT reaches a position; an expired bound is a failure.
   task automatic espera(input int h, input int v, input logic t);
      int n = 0;
      while (!(cuentaH == 10'(h) && cuentaV == 10'(v) && tick_pixel == t) && n < LIMITE) begin
         ciclo(1);
         n++;
      end
      if (n >= LIMITE) begin
         checks++;
         errores++;
         $display("FAIL espera: position (%0d,%0d,%b) not reached, at (%0d,%0d)",
                  h, v, t, cuentaH, cuentaV);
      end
   endtask

   initial begin
      reset     = 1'b1;
      habilitar = 1'b0;
      ciclo(3);
      empuja("reset", 0, 0, 0, 1, 1, 1, 0, 0);
      ciclo(1);
      reset     = 1'b0;
      habilitar = 1'b1;
      c0        = ciclos;

      // First ticks after reset.
      ciclo(1); empuja("tick1",      0, 0, 1, 1, 1, 1, 0, 0);
      ciclo(1); empuja("paso1",      1, 0, 0, 1, 1, 1, 0, 0);
      ciclo(1); empuja("paso1_tick", 1, 0, 1, 1, 1, 1, 0, 0);
      ciclo(1); empuja("paso2",      2, 0, 0, 1, 1, 1, 0, 0);

      // Horizontal phase boundaries.
      espera(639, 0, 1); empuja("h639", 639, 0, 1, 1, 1, 1, 0, 0);
      ciclo(1);          empuja("h640", 640, 0, 0, 1, 1, 0, 0, 0);
      espera(655, 0, 1); empuja("h655", 655, 0, 1, 1, 1, 0, 0, 0);
      ciclo(1);          empuja("h656", 656, 0, 0, 0, 1, 0, 0, 0);
      espera(751, 0, 1); empuja("h751", 751, 0, 1, 0, 1, 0, 0, 0);
      ciclo(1);          empuja("h752", 752, 0, 0, 1, 1, 0, 0, 0);

      // Leaving vertical sync, then the frame wrap.
      espera(799, 14, 1); empuja("v14_fin",  799, 14, 1, 1, 0, 0, 0, 0);
      ciclo(1);           empuja("v15",        0, 15, 0, 1, 1, 0, 1, 0);
      espera(799, 15, 1); empuja("cuadro_pre", 799, 15, 1, 1, 1, 0, 0, 0);
      ciclo(1);           empuja("cuadro",     0,  0, 0, 1, 1, 1, 1, 1);
      checks++;
      if (ciclos - c0 != int'(LARGO_CUADRO)) begin
         errores++;
         $display("FAIL largo_cuadro: got %0d clk, want %0d", ciclos - c0, LARGO_CUADRO);
      end
      ciclo(1);           empuja("cuadro_post", 0, 0, 1, 1, 1, 1, 0, 0);

      // Pause for 37 clk with a tick pending.
      espera(300, 1, 1);
      habilitar = 1'b0;
      empuja("pausa_ini", 300, 1, 0, 1, 1, 1, 0, 0);
      for (int i = 0; i < 36; i++) begin
         ciclo(1);
         empuja("pausa", 300, 1, 0, 1, 1, 1, 0, 0);
      end
      ciclo(1);
      habilitar = 1'b1;
      empuja("reanuda",  300, 1, 1, 1, 1, 1, 0, 0);
      ciclo(1); empuja("h301", 301, 1, 0, 1, 1, 1, 0, 0);

      // Line wrap inside the visible area.
      espera(799, 10, 1); empuja("linea_pre",  799, 10, 1, 1, 1, 0, 0, 0);
      ciclo(1);           empuja("linea",        0, 11, 0, 1, 1, 1, 1, 0);
      ciclo(1);           empuja("linea_post",   0, 11, 1, 1, 1, 1, 0, 0);

      // Entering vertical sync.
      espera(799, 12, 1); empuja("v12_fin", 799, 12, 1, 1, 1, 0, 0, 0);
      ciclo(1);           empuja("v13",       0, 13, 0, 1, 0, 0, 1, 0);

      // Reset in the middle of both sync pulses.
      espera(700, 14, 1);
      empuja("pre_reset", 700, 14, 1, 0, 0, 0, 0, 0);
      reset = 1'b1;
      ciclo(1);
      empuja("reset_medio", 0, 0, 0, 1, 1, 1, 0, 0);
      reset = 1'b0;
      ciclo(1); empuja("post_reset_tick", 0, 0, 1, 1, 1, 1, 0, 0);
      ciclo(1); empuja("post_reset_h1",   1, 0, 0, 1, 1, 1, 0, 0);
      ciclo(2);

      checks++;
      if (cola.size() != 0) begin
         errores++;
         $display("FAIL cola: %0d expectations left, want 0", cola.size());
      end
      checks++;
      if (vs_fuera != 0) begin
         errores++;
         $display("FAIL vsinc_rango: %0d clk with Vsinc low outside lines 13..14, want 0",
                  vs_fuera);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errores);
      $finish;
   end

endmodule
